// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU, NPC, write-data
// select and ALU source-A codes, opcode/funct values, FSM states and the
// instruction-class flags produced by the decoder.
package mc_ctrl_pkg;

   // ALU operation codes; ALU_NOP passes operand A through unchanged (used by lui)
   localparam logic [2:0] ALU_NOP  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;
   localparam logic [2:0] ALU_SLTU = 3'd6;
   localparam logic [2:0] ALU_SLL  = 3'd7;

   // Next-PC selection
   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   // Register-file write data source
   localparam logic WD_ALU = 1'b0;
   localparam logic WD_MEM = 1'b1;

   // ALU operand A source
   localparam logic [1:0] SRCA_RS    = 2'b00;
   localparam logic [1:0] SRCA_SHAMT = 2'b01;
   localparam logic [1:0] SRCA_LUI   = 2'b10;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct values
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Controller states; the numeric values are visible on the State debug port
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   // Instruction class flags; exactly one is set for any Op/Funct pair
   typedef struct packed {
      logic rtype;
      logic itype_alu;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic illegal;
   } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath.
// The controller side is the master; the datapath side is the slave.
interface mc_ctrl_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemRead;
   logic       MemWrite;
   logic       EXTOp;
   logic [2:0] ALUOp;
   logic [1:0] NPCOp;
   logic [1:0] ALUSrcA;
   logic       ALUSrcB;
   logic       GPRSel;
   logic       WDSel;
   logic       Illegal;
   logic       MemErr;
   logic [2:0] State;

   modport master (
      input  Op, Funct, Zero, MemReady,
      output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUOp,
             NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel, Illegal, MemErr, State
   );

   modport slave (
      output Op, Funct, Zero, MemReady,
      input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, ALUOp,
             NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel, Illegal, MemErr, State
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies Op/Funct and produces the
// ALU-side controls used during EXE plus the destination-register select.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec,
   output logic [2:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic       alu_src_b,
   output logic       ext_op,
   output logic       gpr_rt
);

   // Map opcode (and funct for R-type) onto class flags and ALU controls
   always_comb begin
      dec       = '0;
      alu_op    = ALU_NOP;
      alu_src_a = SRCA_RS;
      alu_src_b = 1'b0;
      ext_op    = 1'b0;
      gpr_rt    = 1'b0;
      case (op)
         OP_RTYPE: begin
            dec.rtype = 1'b1;
            case (funct)
               F_ADD, F_ADDU: alu_op = ALU_ADD;
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:         alu_op = ALU_AND;
               F_OR:          alu_op = ALU_OR;
               F_SLT:         alu_op = ALU_SLT;
               F_SLTU:        alu_op = ALU_SLTU;
               F_SLL: begin
                  alu_op    = ALU_SLL;
                  alu_src_a = SRCA_SHAMT;
               end
               default: begin
                  dec.rtype   = 1'b0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            dec.itype_alu = 1'b1;
            alu_op        = ALU_ADD;
            alu_src_b     = 1'b1;
            ext_op        = 1'b1;
            gpr_rt        = 1'b1;
         end
         OP_ORI: begin
            dec.itype_alu = 1'b1;
            alu_op        = ALU_OR;
            alu_src_b     = 1'b1;
            gpr_rt        = 1'b1;
         end
         OP_LUI: begin
            dec.itype_alu = 1'b1;
            alu_op        = ALU_NOP;
            alu_src_a     = SRCA_LUI;
            gpr_rt        = 1'b1;
         end
         OP_LW: begin
            dec.lw    = 1'b1;
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
            gpr_rt    = 1'b1;
         end
         OP_SW: begin
            dec.sw    = 1'b1;
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
         end
         OP_BEQ: begin
            dec.beq = 1'b1;
            alu_op  = ALU_SUB;
         end
         OP_J: dec.j = 1'b1;
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB sequencing, a memory
// ready handshake with a wait-cycle timeout, and per-state enable gating.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
)(
   input logic        clk,
   input logic        rst,
   mc_ctrl_if.master  bus
);

   // Timeout fires on the (MEM_TIMEOUT-1)th consecutive non-ready MEM cycle,
   // comparing the count that includes the current cycle.
   localparam logic [CNT_W:0] TIMEOUT_AT = (CNT_W+1)'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;
   logic             timeout_hit;

   dec_t       dec;
   logic [2:0] dec_alu_op;
   logic [1:0] dec_alu_src_a;
   logic       dec_alu_src_b, dec_ext_op, dec_gpr_rt;

   logic       pc_write, ir_write, reg_write, mem_read, mem_write, ext_op;
   logic [2:0] alu_op;
   logic [1:0] npc_op, alu_src_a;
   logic       alu_src_b, gpr_sel, wd_sel, illegal, mem_err;

   mc_decode u_decode (
      .op        (bus.Op),
      .funct     (bus.Funct),
      .dec       (dec),
      .alu_op    (dec_alu_op),
      .alu_src_a (dec_alu_src_a),
      .alu_src_b (dec_alu_src_b),
      .ext_op    (dec_ext_op),
      .gpr_rt    (dec_gpr_rt)
   );

   assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc >= TIMEOUT_AT);

   // Next-state, wait counter and per-state control outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALU_NOP;
      npc_op    = NPC_PLUS4;
      alu_src_a = SRCA_RS;
      alu_src_b = 1'b0;
      gpr_sel   = 1'b0;
      wd_sel    = WD_ALU;
      illegal   = 1'b0;
      mem_err   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            if (dec.j) begin
               pc_write = 1'b1;
               npc_op   = NPC_JUMP;
               state_d  = S_FETCH;
            end else if (dec.illegal) begin
               illegal  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d  = S_EXE;
            end
         end
         S_EXE: begin
            alu_op    = dec_alu_op;
            alu_src_a = dec_alu_src_a;
            alu_src_b = dec_alu_src_b;
            ext_op    = dec_ext_op;
            if (dec.beq) begin
               pc_write = 1'b1;
               npc_op   = bus.Zero ? NPC_BRANCH : NPC_PLUS4;
               state_d  = S_FETCH;
            end else if (dec.lw || dec.sw) begin
               state_d  = S_MEM;
            end else if (dec.rtype || dec.itype_alu) begin
               state_d  = S_WB;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_MEM: begin
            mem_read  = dec.lw;
            mem_write = dec.sw;
            if (bus.MemReady) begin
               if (dec.lw) begin
                  state_d  = S_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
            end else if (timeout_hit) begin
               mem_err  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else begin
               cnt_d    = cnt_inc[CNT_W-1:0];
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            gpr_sel   = dec_gpr_rt;
            wd_sel    = dec.lw ? WD_MEM : WD_ALU;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // State register and wait counter with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every output is forced low while reset is held, so an abandoned
   // instruction can never write anything in the reset cycle.
   assign bus.PCWrite  = rst ? 1'b0 : pc_write;
   assign bus.IRWrite  = rst ? 1'b0 : ir_write;
   assign bus.RegWrite = rst ? 1'b0 : reg_write;
   assign bus.MemRead  = rst ? 1'b0 : mem_read;
   assign bus.MemWrite = rst ? 1'b0 : mem_write;
   assign bus.EXTOp    = rst ? 1'b0 : ext_op;
   assign bus.ALUOp    = rst ? 3'd0 : alu_op;
   assign bus.NPCOp    = rst ? 2'd0 : npc_op;
   assign bus.ALUSrcA  = rst ? 2'd0 : alu_src_a;
   assign bus.ALUSrcB  = rst ? 1'b0 : alu_src_b;
   assign bus.GPRSel   = rst ? 1'b0 : gpr_sel;
   assign bus.WDSel    = rst ? 1'b0 : wd_sel;
   assign bus.Illegal  = rst ? 1'b0 : illegal;
   assign bus.MemErr   = rst ? 1'b0 : mem_err;
   assign bus.State    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written MEM timeout, ready-wins
// and reset-during-MEM sequences.
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, regw, mrd, mwr, ext;
      logic [2:0] alu;
      logic [1:0] npc, srca;
      logic       srcb, gpr, wd, ill, err;
   } outs_t;

   typedef struct {
      string      name;
      logic       rst;
      logic [5:0] op, funct;
      logic       zero, rdy;
      outs_t      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   nApplied = 0;
   int   nMiss = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mc_ctrl_if bus();

   mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic outs_t base(input logic [2:0] st);
      outs_t o = '0;
      o.st = st;
      return o;
   endfunction

   function automatic outs_t fetchE();
      outs_t o = base(3'd0);
      o.irw = 1'b1;
      return o;
   endfunction

   function automatic outs_t exeE(input logic [2:0] alu, input logic [1:0] srca,
                                  input logic srcb, input logic ext);
      outs_t o = base(3'd2);
      o.alu = alu; o.srca = srca; o.srcb = srcb; o.ext = ext;
      return o;
   endfunction

   function automatic outs_t memE(input logic rd, input logic wr);
      outs_t o = base(3'd3);
      o.mrd = rd; o.mwr = wr;
      return o;
   endfunction

   function automatic outs_t wbE(input logic gpr, input logic wd);
      outs_t o = base(3'd4);
      o.regw = 1'b1; o.pcw = 1'b1; o.gpr = gpr; o.wd = wd;
      return o;
   endfunction

   function automatic vec_t mkVec(input string n, input logic r, input logic [5:0] op,
                                  input logic [5:0] fn, input logic z, input logic rdy,
                                  input outs_t e);
      vec_t v;
      v.name = n; v.rst = r; v.op = op; v.funct = fn; v.zero = z; v.rdy = rdy; v.exp = e;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst          = v.rst;
      bus.Op       = v.op;
      bus.Funct    = v.funct;
      bus.Zero     = v.zero;
      bus.MemReady = v.rdy;
   endtask

   task automatic checkOutput(input string name, input outs_t exp);
      outs_t act;
      #1;
      act.st = bus.State;     act.pcw = bus.PCWrite;  act.irw = bus.IRWrite;
      act.regw = bus.RegWrite; act.mrd = bus.MemRead; act.mwr = bus.MemWrite;
      act.ext = bus.EXTOp;    act.alu = bus.ALUOp;    act.npc = bus.NPCOp;
      act.srca = bus.ALUSrcA; act.srcb = bus.ALUSrcB; act.gpr = bus.GPRSel;
      act.wd = bus.WDSel;     act.ill = bus.Illegal;  act.err = bus.MemErr;
      nApplied++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: outputs got %h expected %h", name, act, exp);
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput(v.name, v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic addFD(input string n, input logic [5:0] op, input logic [5:0] fn);
      vecs.push_back(mkVec({n, "_fetch"}, 1'b0, op, fn, 1'b0, 1'b0, fetchE()));
      vecs.push_back(mkVec({n, "_decode"}, 1'b0, op, fn, 1'b0, 1'b0, base(3'd1)));
   endtask

   initial begin
      outs_t e;

      // Reset vectors and straight-line instruction table
      vecs.push_back(mkVec("reset0", 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, base(3'd0)));
      vecs.push_back(mkVec("reset1", 1'b1, OP_LW, 6'h00, 1'b1, 1'b1, base(3'd0)));

      addFD("add", OP_RTYPE, F_ADD);
      vecs.push_back(mkVec("add_exe", 1'b0, OP_RTYPE, F_ADD, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mkVec("add_wb", 1'b0, OP_RTYPE, F_ADD, 1'b0, 1'b0, wbE(1'b0, 1'b0)));

      addFD("lw", OP_LW, 6'h00);
      vecs.push_back(mkVec("lw_exe", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b1, 1'b1)));
      vecs.push_back(mkVec("lw_mem1", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, memE(1'b1, 1'b0)));
      vecs.push_back(mkVec("lw_mem2", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, memE(1'b1, 1'b0)));
      vecs.push_back(mkVec("lw_mem3", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, memE(1'b1, 1'b0)));
      vecs.push_back(mkVec("lw_mem4", 1'b0, OP_LW, 6'h00, 1'b0, 1'b1, memE(1'b1, 1'b0)));
      vecs.push_back(mkVec("lw_wb", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, wbE(1'b1, 1'b1)));

      addFD("beqz1", OP_BEQ, 6'h00);
      e = exeE(ALU_SUB, 2'b00, 1'b0, 1'b0); e.pcw = 1'b1; e.npc = 2'b01;
      vecs.push_back(mkVec("beqz1_exe", 1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0, e));
      addFD("beqz0", OP_BEQ, 6'h00);
      e.npc = 2'b00;
      vecs.push_back(mkVec("beqz0_exe", 1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0, e));

      vecs.push_back(mkVec("j_fetch", 1'b0, OP_J, 6'h00, 1'b0, 1'b0, fetchE()));
      e = base(3'd1); e.pcw = 1'b1; e.npc = 2'b10;
      vecs.push_back(mkVec("j_decode", 1'b0, OP_J, 6'h00, 1'b0, 1'b0, e));

      vecs.push_back(mkVec("illop_fetch", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, fetchE()));
      e = base(3'd1); e.pcw = 1'b1; e.ill = 1'b1;
      vecs.push_back(mkVec("illop_decode", 1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, e));
      vecs.push_back(mkVec("illfn_fetch", 1'b0, OP_RTYPE, 6'h3F, 1'b0, 1'b0, fetchE()));
      vecs.push_back(mkVec("illfn_decode", 1'b0, OP_RTYPE, 6'h3F, 1'b0, 1'b0, e));

      addFD("ori", OP_ORI, 6'h00);
      vecs.push_back(mkVec("ori_exe", 1'b0, OP_ORI, 6'h00, 1'b0, 1'b0, exeE(ALU_OR, 2'b00, 1'b1, 1'b0)));
      vecs.push_back(mkVec("ori_wb", 1'b0, OP_ORI, 6'h00, 1'b0, 1'b0, wbE(1'b1, 1'b0)));

      addFD("lui", OP_LUI, 6'h00);
      vecs.push_back(mkVec("lui_exe", 1'b0, OP_LUI, 6'h00, 1'b0, 1'b0, exeE(ALU_NOP, 2'b10, 1'b0, 1'b0)));
      vecs.push_back(mkVec("lui_wb", 1'b0, OP_LUI, 6'h00, 1'b0, 1'b0, wbE(1'b1, 1'b0)));

      addFD("sll", OP_RTYPE, F_SLL);
      vecs.push_back(mkVec("sll_exe", 1'b0, OP_RTYPE, F_SLL, 1'b0, 1'b0, exeE(ALU_SLL, 2'b01, 1'b0, 1'b0)));
      vecs.push_back(mkVec("sll_wb", 1'b0, OP_RTYPE, F_SLL, 1'b0, 1'b0, wbE(1'b0, 1'b0)));

      addFD("sltu", OP_RTYPE, F_SLTU);
      vecs.push_back(mkVec("sltu_exe", 1'b0, OP_RTYPE, F_SLTU, 1'b0, 1'b0, exeE(ALU_SLTU, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mkVec("sltu_wb", 1'b0, OP_RTYPE, F_SLTU, 1'b0, 1'b0, wbE(1'b0, 1'b0)));

      addFD("sw", OP_SW, 6'h00);
      vecs.push_back(mkVec("sw_exe", 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b1, 1'b1)));
      e = memE(1'b0, 1'b1); e.pcw = 1'b1;
      vecs.push_back(mkVec("sw_mem", 1'b0, OP_SW, 6'h00, 1'b0, 1'b1, e));

      rst = 1'b1; bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] applying %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

      // sw with MemReady stuck low, twice in a row: the second run shows the
      // wait counter was cleared by the first timeout
      for (int rep = 0; rep < 2; rep++) begin
         addFD("swto", OP_SW, 6'h00);
         runVec(vecs[vecs.size()-2]);
         runVec(vecs[vecs.size()-1]);
         runVec(mkVec("swto_exe", 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b1, 1'b1)));
         for (int i = 1; i <= 14; i++) begin
            e = memE(1'b0, 1'b1);
            if (i == 14) begin
               e.err = 1'b1;
               e.pcw = 1'b1;
            end
            runVec(mkVec($sformatf("swto%0d_mem%0d", rep, i), 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, e));
         end
      end
      runVec(mkVec("swto_after", 1'b0, OP_SW, 6'h00, 1'b0, 1'b0, fetchE()));

      // lw where MemReady arrives in the cycle the timeout would fire
      runVec(mkVec("lwrw_decode", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, base(3'd1)));
      runVec(mkVec("lwrw_exe", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b1, 1'b1)));
      for (int i = 1; i <= 14; i++)
         runVec(mkVec($sformatf("lwrw_mem%0d", i), 1'b0, OP_LW, 6'h00, 1'b0, (i == 14), memE(1'b1, 1'b0)));
      runVec(mkVec("lwrw_wb", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, wbE(1'b1, 1'b1)));

      // Reset asserted while lw waits in MEM
      runVec(mkVec("lwrst_fetch", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, fetchE()));
      runVec(mkVec("lwrst_decode", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, base(3'd1)));
      runVec(mkVec("lwrst_exe", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, exeE(ALU_ADD, 2'b00, 1'b1, 1'b1)));
      runVec(mkVec("lwrst_mem", 1'b0, OP_LW, 6'h00, 1'b0, 1'b0, memE(1'b1, 1'b0)));
      runVec(mkVec("lwrst_rst", 1'b1, OP_LW, 6'h00, 1'b0, 1'b1, base(3'd0)));
      runVec(mkVec("lwrst_fetch2", 1'b0, OP_LW, 6'h00, 1'b0, 1'b1, fetchE()));
      runVec(mkVec("lwrst_decode2", 1'b0, OP_LW, 6'h00, 1'b0, 1'b1, base(3'd1)));

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule
